ex_div: RTL and testbench

//  Iterative restoring divider living in the EX stage; executes DIV/DIVU over WIDTH cycles.

---
 rtl/mips_pkg.sv | 16 +
 rtl/ex_div_if.sv | 25 ++
 rtl/div_step.sv | 30 +++
 rtl/ex_div.sv | 106 ++++++++++
 tb/tb_ex_div.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions used by the EX-stage divider: state encoding, width, funct codes.
package mips_pkg;

   localparam int DIV_WIDTH = 32;

   localparam logic [5:0] FUNCT_DIV  = 6'b011010;
   localparam logic [5:0] FUNCT_DIVU = 6'b011011;

   typedef enum logic [1:0] {
      DIV_FREE,
      DIV_BYZERO,
      DIV_ON,
      DIV_END
   } div_state_t;

endpackage

// File: rtl/ex_div_if.sv
// EX-stage <-> divider handshake: start/operands/annul in, result/ready/stall request out.
interface ex_div_if
   import mips_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
);
   logic               i_start;
   logic               i_signed_div;
   logic [WIDTH-1:0]   i_opdata1;
   logic [WIDTH-1:0]   i_opdata2;
   logic               i_annul;
   logic [2*WIDTH-1:0] o_result;
   logic               o_ready;
   logic               o_stallreq;

   modport master (
      output i_start, i_signed_div, i_opdata1, i_opdata2, i_annul,
      input  o_result, o_ready, o_stallreq
   );

   modport slave (
      input  i_start, i_signed_div, i_opdata1, i_opdata2, i_annul,
      output o_result, o_ready, o_stallreq
   );
endinterface

// File: rtl/div_step.sv
// One combinational restoring-division iteration on magnitudes: shift {rem,quo}, trial-subtract divisor.
module div_step
   import mips_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_nxt,
   output logic [WIDTH-1:0] quo_nxt
);
   logic [WIDTH:0]   shifted;
   logic [WIDTH-1:0] trial;
   logic             borrow;

   assign shifted = {rem, quo[WIDTH-1]};
   // When no borrow the true difference is below the divisor, so WIDTH bits hold it exactly.
   assign trial   = shifted[WIDTH-1:0] - divisor;
   assign borrow  = shifted < {1'b0, divisor};

   always_comb begin
      rem_nxt = trial;
      quo_nxt = {quo[WIDTH-2:0], 1'b1};
      if (borrow) begin
         rem_nxt = shifted[WIDTH-1:0];
         quo_nxt = {quo[WIDTH-2:0], 1'b0};
      end
   end
endmodule

// File: rtl/ex_div.sv
// EX-stage iterative restoring divider (DIV/DIVU), WIDTH steps, stalls the front end while busy.
// Define DIV_EARLY_OUT_EN to finish in two cycles when |dividend| < |divisor|.
//
//  state      | meaning
//  -----------+-----------------------------------------------------------
//  DIV_FREE   | idle, waiting for an un-annulled start
//  DIV_BYZERO | short path: zero divisor (result 0) or early-out (quo 0)
//  DIV_ON     | one restoring step per clock, counter 0..WIDTH-1
//  DIV_END    | o_ready high, result held until start drops
module ex_div
   import mips_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input logic     clk,
   input logic     rst,
   ex_div_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);

   div_state_t         state, state_nxt;
   logic [CW-1:0]      cnt;
   logic [WIDTH-1:0]   rem_r, quo_r, dvsr_r;
   logic [WIDTH-1:0]   rem_nxt, quo_nxt;
   logic [WIDTH-1:0]   abs1, abs2;
   logic [2*WIDTH-1:0] result_r;
   logic               neg_quo, neg_rem;
   logic               sign1, sign2, start_ok, last_step, early;

   assign sign1     = bus.i_signed_div & bus.i_opdata1[WIDTH-1];
   assign sign2     = bus.i_signed_div & bus.i_opdata2[WIDTH-1];
   assign abs1      = sign1 ? -bus.i_opdata1 : bus.i_opdata1;
   assign abs2      = sign2 ? -bus.i_opdata2 : bus.i_opdata2;
   assign start_ok  = bus.i_start & ~bus.i_annul;
   assign last_step = (cnt == CW'(WIDTH - 1));

`ifdef DIV_EARLY_OUT_EN
   assign early = (abs1 < abs2);
`else
   assign early = 1'b0;
`endif

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem     (rem_r),
      .quo     (quo_r),
      .divisor (dvsr_r),
      .rem_nxt (rem_nxt),
      .quo_nxt (quo_nxt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= DIV_FREE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         DIV_FREE:   if (start_ok) state_nxt = ((abs2 == '0) || early) ? DIV_BYZERO : DIV_ON;
         DIV_ON:     if (bus.i_annul) state_nxt = DIV_FREE;
                     else if (last_step) state_nxt = DIV_END;
         DIV_BYZERO: state_nxt = bus.i_annul ? DIV_FREE : DIV_END;
         DIV_END:    if (bus.i_annul || !bus.i_start) state_nxt = DIV_FREE;
         default:    state_nxt = DIV_FREE;
      endcase
   end

   // Early-out preloads the dividend magnitude as the remainder; zero divisor leaves it 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt      <= '0;
         rem_r    <= '0;
         quo_r    <= '0;
         dvsr_r   <= '0;
         neg_quo  <= 1'b0;
         neg_rem  <= 1'b0;
         result_r <= '0;
      end else begin
         case (state)
            DIV_FREE: if (start_ok) begin
               dvsr_r  <= abs2;
               neg_quo <= sign1 ^ sign2;
               neg_rem <= sign1;
               cnt     <= '0;
               rem_r   <= early ? abs1 : '0;
               quo_r   <= early ? '0 : abs1;
            end
            DIV_ON: begin
               rem_r <= rem_nxt;
               quo_r <= quo_nxt;
               cnt   <= cnt + CW'(1);
               if (last_step && !bus.i_annul)
                  result_r <= {neg_rem ? -rem_nxt : rem_nxt, neg_quo ? -quo_nxt : quo_nxt};
            end
            DIV_BYZERO: if (!bus.i_annul)
               result_r <= {neg_rem ? -rem_r : rem_r, {WIDTH{1'b0}}};
            default: ;
         endcase
      end
   end

   assign bus.o_result   = result_r;
   assign bus.o_ready    = (state == DIV_END);
   assign bus.o_stallreq = ~bus.i_annul & (((state == DIV_FREE) & bus.i_start) |
                                           (state == DIV_ON) | (state == DIV_BYZERO));
endmodule

// File: tb/tb_ex_div.sv
// Self-checking bench for ex_div: directed corner cases plus random DIV/DIVU against an arithmetic model.
module tb_ex_div;
   import mips_pkg::*;
   localparam int W = DIV_WIDTH;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;

   ex_div_if #(.WIDTH(W)) dif();
   ex_div #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(dif));

   always #5 clk = ~clk;

   function automatic logic [2*W-1:0] ref_div(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
      int sa, sb;
      if (b == '0) return '0;
      if (!s) return {a % b, a / b};
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
      sa = $signed(a);
      sb = $signed(b);
      return {32'(sa % sb), 32'(sa / sb)};
   endfunction

   function automatic int ref_lat(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] ma, mb;
      ma = (s && a[W-1]) ? 32'(0) - a : a;
      mb = (s && b[W-1]) ? 32'(0) - b : b;
      if (b == '0) return 2;
`ifdef DIV_EARLY_OUT_EN
      if (ma < mb) return 2;
`else
      if (ma < mb && ma == '1) return 0;
`endif
      return W + 1;
   endfunction

   task automatic drive_idle();
      dif.i_start      = 1'b0;
      dif.i_signed_div = 1'b0;
      dif.i_opdata1    = '0;
      dif.i_opdata2    = '0;
      dif.i_annul      = 1'b0;
   endtask

   task automatic do_op(input bit s, input logic [W-1:0] a, input logic [W-1:0] b, input int hold, input string tag);
      logic [2*W-1:0] exp;
      int lat;
      exp = ref_div(s, a, b);
      lat = ref_lat(s, a, b);
      @(posedge clk); #1;
      dif.i_start = 1'b1; dif.i_signed_div = s; dif.i_opdata1 = a; dif.i_opdata2 = b;
      for (int c = 0; c <= lat + hold; c++) begin
         @(negedge clk);
         n_vec++;
         if (dif.o_stallreq !== (c < lat)) begin
            n_err++;
            $display("FAIL %s stallreq cyc=%0d got=%b exp=%b", tag, c, dif.o_stallreq, (c < lat));
         end
         n_vec++;
         if (dif.o_ready !== (c >= lat)) begin
            n_err++;
            $display("FAIL %s ready cyc=%0d got=%b exp=%b", tag, c, dif.o_ready, (c >= lat));
         end
         if (c >= lat) begin
            n_vec++;
            if (dif.o_result !== exp) begin
               n_err++;
               $display("FAIL %s result cyc=%0d got=%h exp=%h", tag, c, dif.o_result, exp);
            end
         end
         @(posedge clk); #1;
         if (c == 0) begin
            dif.i_opdata1 = $urandom; dif.i_opdata2 = $urandom; dif.i_signed_div = 1'($urandom);
         end
      end
      dif.i_start = 1'b0;
      @(negedge clk);
      n_vec++;
      if (dif.o_ready !== 1'b1 || dif.o_stallreq !== 1'b0) begin
         n_err++;
         $display("FAIL %s end_hold got ready=%b stall=%b exp ready=1 stall=0", tag, dif.o_ready, dif.o_stallreq);
      end
      @(posedge clk); #1;
      @(negedge clk);
      n_vec++;
      if (dif.o_ready !== 1'b0) begin
         n_err++;
         $display("FAIL %s ready_drop got=%b exp=0", tag, dif.o_ready);
      end
   endtask

   task automatic test_reset();
      drive_idle();
      #1 rst = 1'b1;
      #2;
      n_vec++;
      if (dif.o_ready !== 1'b0 || dif.o_stallreq !== 1'b0 || dif.o_result !== '0) begin
         n_err++;
         $display("FAIL reset got ready=%b stall=%b result=%h exp 0/0/0", dif.o_ready, dif.o_stallreq, dif.o_result);
      end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_directed();
      do_op(1'b0, 32'd100, 32'd7, 3, "divu_100_7");
      do_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0, "div_m7_2");
      do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1, "div_min_m1");
      do_op(1'b0, 32'd12345, 32'd0, 2, "div_by_zero");
      do_op(1'b1, 32'd3, 32'd9, 1, "div_3_9");
      do_op(1'b1, 32'hFFFF_FFFD, 32'd9, 0, "div_m3_9");
      do_op(1'b0, 32'hFFFF_FFFF, 32'd1, 0, "divu_max_1");
   endtask

   task automatic test_annul();
      @(posedge clk); #1;
      dif.i_start = 1'b1; dif.i_signed_div = 1'b0; dif.i_opdata1 = 32'd1000; dif.i_opdata2 = 32'd3;
      repeat (10) begin @(posedge clk); #1; end
      dif.i_annul = 1'b1;
      @(negedge clk);
      n_vec++;
      if (dif.o_stallreq !== 1'b0 || dif.o_ready !== 1'b0) begin
         n_err++;
         $display("FAIL annul_on got stall=%b ready=%b exp 0/0", dif.o_stallreq, dif.o_ready);
      end
      @(posedge clk); #1;
      dif.i_annul = 1'b0; dif.i_start = 1'b0;
      for (int c = 0; c < 36; c++) begin
         @(negedge clk);
         n_vec++;
         if (dif.o_ready !== 1'b0 || dif.o_stallreq !== 1'b0) begin
            n_err++;
            $display("FAIL annul_after cyc=%0d got ready=%b stall=%b exp 0/0", c, dif.o_ready, dif.o_stallreq);
         end
      end
      @(posedge clk); #1;
      dif.i_start = 1'b1; dif.i_annul = 1'b1; dif.i_opdata2 = 32'd0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_vec++;
         if (dif.o_stallreq !== 1'b0 || dif.o_ready !== 1'b0) begin
            n_err++;
            $display("FAIL annul_free cyc=%0d got stall=%b ready=%b exp 0/0", c, dif.o_stallreq, dif.o_ready);
         end
         @(posedge clk); #1;
      end
      dif.i_start = 1'b0; dif.i_annul = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         n_vec++;
         if (dif.o_ready !== 1'b0) begin
            n_err++;
            $display("FAIL annul_free_idle cyc=%0d got ready=%b exp=0", c, dif.o_ready);
         end
      end
      do_op(1'b0, 32'd1000, 32'd3, 0, "after_annul");
   endtask

   task automatic test_rst_mid();
      do_op(1'b0, 32'd77, 32'd5, 0, "pre_rst");
      @(posedge clk); #1;
      dif.i_start = 1'b1; dif.i_signed_div = 1'b1; dif.i_opdata1 = 32'd500; dif.i_opdata2 = 32'd7;
      repeat (5) begin @(posedge clk); #1; end
      rst = 1'b1; dif.i_start = 1'b0;
      #1;
      n_vec++;
      if (dif.o_result !== '0 || dif.o_ready !== 1'b0 || dif.o_stallreq !== 1'b0) begin
         n_err++;
         $display("FAIL rst_mid got result=%h ready=%b stall=%b exp 0/0/0", dif.o_result, dif.o_ready, dif.o_stallreq);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      do_op(1'b1, 32'd500, 32'd7, 0, "after_rst");
   endtask

   task automatic test_random();
      bit s;
      logic [W-1:0] a, b;
      for (int i = 0; i < 24; i++) begin
         s = 1'($urandom);
         a = $urandom;
         case ($urandom_range(0, 3))
            0: b = '0;
            1: b = 32'($urandom_range(1, 15));
            2: b = $urandom;
            default: begin b = $urandom; a = 32'($urandom_range(0, 40)); end
         endcase
         if (s && $urandom_range(0, 1) == 1) b = 32'(0) - b;
         do_op(s, a, b, $urandom_range(0, 2), "random");
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog time limit exceeded got=running exp=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_directed();
      test_annul();
      test_rst_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
